// File: rtl/rsa_job_arbiter.sv
// rtl/rsa_job_arbiter.sv - round-robin arbiter sharing one RSA engine among N_REQ requesters
//
// Accepts one job (msg, key, modulus) at a time from the requester selected
// round-robin. It issues that job to the engine and returns the engine result
// to the job owner. Exactly one job is in flight.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_req_valid/i_req_ready       per-requester job handshake (ready is one-hot)
//   i_req_msg/key/modulus         packed operands, requester k at [k*MOD_WIDTH +: MOD_WIDTH]
//   o_rsp_valid/o_rsp_ready       per-requester result handshake (valid is one-hot)
//   o_rsp_crypto                  shared result bus
//   eng_i_valid/ready, eng_i_*    job channel to the engine
//   eng_o_valid/ready, eng_o_*    result channel from the engine
//   o_busy                        high while a job is in flight
//   o_owner                       index of the current / last job owner
//   o_jobs_done                   completed response handshakes, wraps at 2^16
module rsa_job_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MOD_WIDTH = 256,
    parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           i_req_valid,
    output logic [N_REQ-1:0]           i_req_ready,
    input  logic [N_REQ*MOD_WIDTH-1:0] i_req_msg,
    input  logic [N_REQ*MOD_WIDTH-1:0] i_req_key,
    input  logic [N_REQ*MOD_WIDTH-1:0] i_req_modulus,
    output logic [N_REQ-1:0]           o_rsp_valid,
    input  logic [N_REQ-1:0]           o_rsp_ready,
    output logic [MOD_WIDTH-1:0]       o_rsp_crypto,
    output logic                       eng_i_valid,
    input  logic                       eng_i_ready,
    output logic [MOD_WIDTH-1:0]       eng_i_msg,
    output logic [MOD_WIDTH-1:0]       eng_i_key,
    output logic [MOD_WIDTH-1:0]       eng_i_modulus,
    input  logic                       eng_o_valid,
    output logic                       eng_o_ready,
    input  logic [MOD_WIDTH-1:0]       eng_o_crypto,
    output logic                       o_busy,
    output logic [ID_W-1:0]            o_owner,
    output logic [15:0]                o_jobs_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    state_t state, state_nxt;

    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      owner;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W-1:0]      ptr_nxt;
    logic                 grant_found;
    logic [ID_W-1:0]      hi_idx;
    logic [ID_W-1:0]      lo_idx;
    logic                 hi_found;
    logic                 lo_found;
    logic [MOD_WIDTH-1:0] msg_q;
    logic [MOD_WIDTH-1:0] key_q;
    logic [MOD_WIDTH-1:0] mod_q;
    logic [MOD_WIDTH-1:0] result_q;
    logic [15:0]          jobs_done_q;

    // Rotating priority without a dynamic rotate: the lowest valid index at or
    // above rr_ptr wins; failing that, the lowest valid index below rr_ptr
    // (the wrap-around). Scanning downward leaves the lowest match in each half.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[k]) begin
                if (k >= int'(rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(k);
                end
            end
        end
        grant_found = hi_found | lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Explicit wrap keeps non-power-of-two N_REQ (and N_REQ=1) correct.
    assign ptr_nxt = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        i_req_ready = '0;
        eng_i_valid = 1'b0;
        eng_o_ready = 1'b0;
        o_rsp_valid = '0;
        case (state)
            ST_IDLE: begin
                // Ready is only raised toward a valid winner, so a grant is a handshake.
                if (grant_found) begin
                    i_req_ready[grant_idx] = 1'b1;
                    state_nxt              = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_i_valid = 1'b1;
                if (eng_i_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                eng_o_ready = 1'b1;
                if (eng_o_valid) begin
                    state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                o_rsp_valid[owner] = 1'b1;
                if (o_rsp_ready[owner]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            owner       <= '0;
            msg_q       <= '0;
            key_q       <= '0;
            mod_q       <= '0;
            result_q    <= '0;
            jobs_done_q <= '0;
        end else begin
            if (state == ST_IDLE && grant_found) begin
                msg_q  <= i_req_msg[grant_idx*MOD_WIDTH +: MOD_WIDTH];
                key_q  <= i_req_key[grant_idx*MOD_WIDTH +: MOD_WIDTH];
                mod_q  <= i_req_modulus[grant_idx*MOD_WIDTH +: MOD_WIDTH];
                owner  <= grant_idx;
                rr_ptr <= ptr_nxt;
            end
            // Engine results outside WAIT are strays and never touch result_q.
            if (state == ST_WAIT && eng_o_valid) begin
                result_q <= eng_o_crypto;
            end
            if (state == ST_RESPOND && o_rsp_ready[owner]) begin
                jobs_done_q <= jobs_done_q + 16'd1;
            end
        end
    end

    assign eng_i_msg     = msg_q;
    assign eng_i_key     = key_q;
    assign eng_i_modulus = mod_q;
    assign o_rsp_crypto  = result_q;
    assign o_busy        = (state != ST_IDLE);
    assign o_owner       = owner;
    assign o_jobs_done   = jobs_done_q;

endmodule
